// File: rtl/ram_wr_packer.sv
// ram_wr_packer: packs a stream of W-bit activations, nine per 72-bit word,
// and writes them into a circular region of the URAM feature buffer through
// its port-1 write interface.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   clear              synchronous abort; drops the frame with no write
//   start              one-cycle frame start; base_addr/region_words sampled
//   base_addr          first word address of the circular region
//   region_words       region size in words (0 means 2^N)
//   s_valid/s_ready    element handshake; s_data element, s_last frame end
//   we/addr1/data_in1  registered buffer write, one pulse per packed word
//   busy               frame in progress
//   done               one-cycle completion pulse, coincident with last we
//   word_count         words written in the current/last frame
//   wrapped            region wrapped at least once this frame (sticky)
module ram_wr_packer #(
  parameter int unsigned N = 22,
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           start,
  input  logic [N-1:0]   base_addr,
  input  logic [N-1:0]   region_words,
  input  logic           s_valid,
  input  logic [W-1:0]   s_data,
  input  logic           s_last,
  output logic           s_ready,
  output logic           we,
  output logic [N-1:0]   addr1,
  output logic [W*9-1:0] data_in1,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   word_count,
  output logic           wrapped
);

  localparam int unsigned LANES = 9;
  localparam int unsigned DW    = W * LANES;

  typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  wr_ptr_q, wr_ptr_d;
  logic [N-1:0]  base_q, base_d;
  logic [N-1:0]  last_q, last_d;
  logic [3:0]    lane_q, lane_d;
  logic [DW-1:0] pack_q, pack_d;
  logic          we_q, we_d;
  logic [N-1:0]  addr1_q, addr1_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic [N-1:0]  word_count_q, word_count_d;
  logic          wrapped_q, wrapped_d;

  logic          hs;
  logic [DW-1:0] packed_word;

  assign s_ready    = (state_q == PACK);
  assign busy       = (state_q != IDLE);
  assign hs         = s_valid & s_ready;
  assign we         = we_q;
  assign addr1      = addr1_q;
  assign data_in1   = data_q;
  assign done       = done_q;
  assign word_count = word_count_q;
  assign wrapped    = wrapped_q;

  // Pack register with the incoming element merged into its lane.
  always_comb begin
    packed_word = pack_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_q == 4'(i)) begin
        packed_word[i*W +: W] = s_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    base_d       = base_q;
    last_d       = last_q;
    lane_d       = lane_q;
    pack_d       = pack_q;
    we_d         = 1'b0;
    addr1_d      = addr1_q;
    data_d       = data_q;
    done_d       = 1'b0;
    word_count_d = word_count_q;
    wrapped_d    = wrapped_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          wr_ptr_d     = base_addr;
          base_d       = base_addr;
          // Wrap point kept as last address; region_words=0 lands on base-1,
          // giving a free-running 2^N wrap.
          last_d       = base_addr + region_words - N'(1);
          word_count_d = '0;
          wrapped_d    = 1'b0;
          lane_d       = '0;
          pack_d       = '0;
          state_d      = PACK;
        end
      end
      PACK: begin
        if (hs) begin
          if (lane_q == 4'(LANES - 1) || s_last) begin
            we_d         = 1'b1;
            addr1_d      = wr_ptr_q;
            data_d       = packed_word;
            word_count_d = word_count_q + N'(1);
            lane_d       = '0;
            pack_d       = '0;
            if (wr_ptr_q == last_q) begin
              wr_ptr_d  = base_q;
              wrapped_d = 1'b1;
            end else begin
              wr_ptr_d = wr_ptr_q + N'(1);
            end
            if (s_last) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else begin
            lane_d = lane_q + 4'd1;
            pack_d = packed_word;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything decided above, including a completing write.
    if (clear) begin
      state_d      = IDLE;
      we_d         = 1'b0;
      done_d       = 1'b0;
      addr1_d      = addr1_q;
      data_d       = data_q;
      word_count_d = word_count_q;
      wrapped_d    = wrapped_q;
      lane_d       = '0;
      pack_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      base_q       <= '0;
      last_q       <= '0;
      lane_q       <= '0;
      pack_q       <= '0;
      we_q         <= 1'b0;
      addr1_q      <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
      word_count_q <= '0;
      wrapped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      base_q       <= base_d;
      last_q       <= last_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      we_q         <= we_d;
      addr1_q      <= addr1_d;
      data_q       <= data_d;
      done_q       <= done_d;
      word_count_q <= word_count_d;
      wrapped_q    <= wrapped_d;
    end
  end

endmodule

// File: doc/ram_wr_packer.md
Name: ram_wr_packer

Overview:
- Upstream write stage for the 72-bit dual-port URAM feature buffer.
- Accepts a stream of W-bit activations on a valid/ready handshake and packs 9 elements per 72-bit word.
- Drives the buffer's port-1 write signals (we, addr1, data_in1) with sequential addresses inside a programmable circular region.
- Signals frame completion to the layer controller.

Parameters:
- N, 22, address width; matches the buffer address width.
- W, 8, element width; W*9 must equal 72 (fixed lane count of 9).

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous soft abort.
- start  input  1  one-cycle frame start pulse.
- base_addr  input  N  first word address of region; sampled at start.
- region_words  input  N  region size in words, ≥1; sampled at start.
- s_valid  input  1  element valid.
- s_data  input  W  element.
- s_last  input  1  marks final element of frame.
- s_ready  output  1  element accept.
- we  output  1  buffer write enable, one-cycle pulse per word.
- addr1  output  N  buffer write address.
- data_in1  output  72  packed write word.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle frame completion pulse.
- word_count  output  N  words written in current/last frame.
- wrapped  output  1  sticky; region wrapped at least once this frame.

Behaviour:
- Reset (rst_n=0, async): state IDLE; s_ready, we, busy, done, wrapped = 0; addr1, data_in1, word_count = 0; lane index = 0; pack register = 0.
- States: IDLE, PACK, DONE.
- IDLE:
  - s_ready = 0.
  - start=1: latch base_addr into wr_ptr and region registers; clear word_count, wrapped, lane, and pack register; go to PACK; busy = 1 from the next cycle.
- PACK:
  - s_ready = 1.
  - Handshake = s_valid & s_ready. On a handshake, s_data goes to bits [W*lane+W-1 : W*lane]; lane 0 is the LSB.
  - A word completes on a handshake with lane==8, or with s_last=1 at any lane.
  - On completion: the next cycle has we=1, addr1=wr_ptr, and data_in1 equal to the packed word. Unfilled lanes are 0, so a partial word is zero-padded in the upper lanes.
  - Latency: exactly 1 cycle from the completing handshake to we. word_count increments in the same cycle as we.
  - After completion, lane and pack register reset to 0.
  - Back-to-back completions are possible every 9 accepted elements; no stall is needed.
- Address advance after each write:
  - If wr_ptr == base + region_words − 1 (mod 2^N): wr_ptr = base and wrapped = 1.
  - Otherwise: wr_ptr + 1 (mod 2^N).
- s_last handshake: go to DONE; s_ready drops the following cycle.
- DONE:
  - Lasts one cycle, coincident with the final we.
  - done = 1, then go to IDLE with busy = 0.
- we, addr1, data_in1, done are registered outputs. addr1 and data_in1 hold their value when we=0.
- word_count and wrapped hold after the frame until the next start.
- start while busy: ignored.
- clear (synchronous, priority over all except rst_n):
  - Go to IDLE; s_ready = 0; busy = 0.
  - Discard the partial word; no we or done is produced by the aborted frame.
  - A we already registered this cycle is suppressed.
  - word_count and wrapped hold.
- s_valid gaps: pack state holds. s_data is ignored without a handshake.
- region_words=0: treated as 2^N (free-running wrap at the address width).
- rst_n asserted mid-frame: immediate return to reset values; nothing is written.

Test Plan:
- Full words: base_addr=0x100, region_words=16, stream 0x01..0x12, s_last on 0x12.
  - we at 0x100, data 0x090807060504030201.
  - we at 0x101, data 0x1211100F0E0D0C0B0A.
  - done with the second we; word_count=2; wrapped=0.
- Partial word: base 0x0, elements 0x01..0x04 with s_last on 0x04.
  - Single we at 0x0, data 0x000000000004030201.
  - word_count=1.
- Wrap: base 0x10, region_words=2, 27 elements.
  - Writes at 0x10, 0x11, 0x10; wrapped=1; word_count=3.
- Backpressure/gaps: same stream as the first scenario with s_valid toggled randomly.
  - Identical writes and data to the first scenario.
  - Each we exactly 1 cycle after the completing handshake.
- Abort: clear after 5 accepted elements.
  - No we, no done; s_ready=0 next cycle; busy=0.
  - Next start with 9 elements writes a clean word at the new base.
- Reset and start robustness:
  - rst_n low mid-word: all outputs return to reset values asynchronously.
  - start pulsed during PACK: no effect on wr_ptr or the frame.
